// File: rtl/cpu_controller_if.sv
// cpu_controller_if
//   Bundles the instruction handshake and the datapath control bus of the
//   16-bit CPU controller.
//   Ports (signals):
//     in[15:0]    instruction word offered for IR capture
//     load        IR load request
//     s           start request
//     w           controller idle / ready
//     readnum, writenum, write, vsel, loada, loadb, asel, bsel,
//     shift, ALUop, loadc, loads   datapath control strobes and selects
//     sximm8, sximm5               sign-extended immediates from IR
//   Modports:
//     master  upstream/datapath side (drives in/load/s)
//     slave   the controller itself
interface cpu_controller_if;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [3:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic        loadc;
    logic        loads;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    modport master (
        output in, load, s,
        input  w, readnum, writenum, write, vsel, loada, loadb, asel, bsel,
               shift, ALUop, loadc, loads, sximm8, sximm5
    );

    modport slave (
        input  in, load, s,
        output w, readnum, writenum, write, vsel, loada, loadb, asel, bsel,
               shift, ALUop, loadc, loads, sximm8, sximm5
    );
endinterface

// File: rtl/cpu_controller.sv
// cpu_controller
//   Holds the instruction register and sequences the 16-bit datapath through
//   a multicycle Moore FSM. Executes MOV imm, MOV reg, ADD, CMP, AND, MVN.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset (state WAIT, IR cleared)
//     bus      cpu_controller_if.slave: in/load/s handshake in, w and all
//              datapath controls plus sximm8/sximm5 out
module cpu_controller (
    input  logic                   clk,
    input  logic                   reset_n,
    cpu_controller_if.slave        bus
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WR_IMM,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WR_REG
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn, rd, rm;
    logic [1:0] sh;
    logic       is_alu, is_mov_imm, is_mov_reg, is_mvn, is_cmp;

    assign opcode     = ir_q[15:13];
    assign op         = ir_q[12:11];
    assign rn         = ir_q[10:8];
    assign rd         = ir_q[7:5];
    assign sh         = ir_q[4:3];
    assign rm         = ir_q[2:0];
    assign is_alu     = (opcode == 3'b101);
    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_mvn     = is_alu && (op == 2'b11);
    assign is_cmp     = is_alu && (op == 2'b01);

    assign bus.sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
    assign bus.sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

    // IR only accepts a new word while idle, so an instruction in flight
    // always sees a stable IR.
    always_comb begin
        ir_d = ir_q;
        if (state_q == S_WAIT && bus.load) begin
            ir_d = bus.in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.w        = 1'b0;
        bus.readnum  = '0;
        bus.writenum = '0;
        bus.write    = 1'b0;
        bus.vsel     = '0;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.asel     = 1'b0;
        bus.bsel     = 1'b0;
        bus.shift    = '0;
        bus.ALUop    = '0;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;

        unique case (state_q)
            S_WAIT: begin
                bus.w = 1'b1;
                if (bus.s) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm)                state_d = S_WR_IMM;
                else if (is_mov_reg || is_mvn) state_d = S_GET_B;
                else if (is_alu)               state_d = S_GET_A;
                else                           state_d = S_WAIT;
            end
            S_WR_IMM: begin
                bus.writenum = rn;
                bus.vsel     = 4'b0010;
                bus.write    = 1'b1;
                state_d      = S_WAIT;
            end
            S_GET_A: begin
                bus.readnum = rn;
                bus.loada   = 1'b1;
                state_d     = S_GET_B;
            end
            S_GET_B: begin
                bus.readnum = rm;
                bus.loadb   = 1'b1;
                state_d     = S_EXEC;
            end
            S_EXEC: begin
                bus.shift = sh;
                bus.loadc = 1'b1;
                // MOV reg passes B through the ALU as 0 + B.
                bus.ALUop = is_alu ? op : 2'b00;
                bus.asel  = is_mov_reg;
                bus.loads = is_cmp;
                state_d   = is_cmp ? S_WAIT : S_WR_REG;
            end
            S_WR_REG: begin
                bus.writenum = rd;
                bus.vsel     = 4'b1000;
                bus.write    = 1'b1;
                state_d      = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
module tb_cpu_controller;

    typedef struct packed {
        logic       w;
        logic [2:0] rn;
        logic [2:0] wn;
        logic       wr;
        logic [3:0] vsel;
        logic       la;
        logic       lb;
        logic       as;
        logic       bs;
        logic [1:0] sh;
        logic [1:0] alu;
        logic       lc;
        logic       ls;
    } ctl_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    ctl_t exp_q[$];

    always #5 clk = ~clk;

    cpu_controller_if bus();

    cpu_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    function automatic ctl_t observed();
        ctl_t c;
        c.w = bus.w; c.rn = bus.readnum; c.wn = bus.writenum; c.wr = bus.write;
        c.vsel = bus.vsel; c.la = bus.loada; c.lb = bus.loadb; c.as = bus.asel;
        c.bs = bus.bsel; c.sh = bus.shift; c.alu = bus.ALUop; c.lc = bus.loadc;
        c.ls = bus.loads;
        return c;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected per-cycle control vectors, starting at the cycle after s is sampled.
    task automatic push_expected(input logic [15:0] i, output int lat);
        logic [2:0] opc;
        logic [1:0] op;
        ctl_t c, idle, ex;
        opc = i[15:13];
        op  = i[12:11];
        idle = '0; idle.w = 1'b1;
        exp_q.push_back(ctl_t'('0));               // DECODE
        ex = '0; ex.sh = i[4:3]; ex.lc = 1'b1;
        ex.alu = (opc == 3'b101) ? op : 2'b00;
        ex.as  = (opc == 3'b110);
        ex.ls  = (opc == 3'b101) && (op == 2'b01);
        if (opc == 3'b110 && op == 2'b10) begin
            c = '0; c.wn = i[10:8]; c.vsel = 4'b0010; c.wr = 1'b1;
            exp_q.push_back(c);
            lat = 2;
        end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11) ||
                     opc == 3'b101) begin
            lat = 3;
            if (!(opc == 3'b110 || op == 2'b11)) begin
                c = '0; c.rn = i[10:8]; c.la = 1'b1;
                exp_q.push_back(c);
                lat++;
            end
            c = '0; c.rn = i[2:0]; c.lb = 1'b1;
            exp_q.push_back(c);
            exp_q.push_back(ex);
            if (!(opc == 3'b101 && op == 2'b01)) begin
                c = '0; c.wn = i[7:5]; c.vsel = 4'b1000; c.wr = 1'b1;
                exp_q.push_back(c);
                lat++;
            end
        end else begin
            lat = 1;
        end
        exp_q.push_back(idle);
    endtask

    task automatic run_instr(input string name, input logic [15:0] i, input bit mid_load);
        int   lat, wlow;
        ctl_t e, o;
        @(negedge clk);
        bus.in = i; bus.load = 1'b1; bus.s = 1'b1;
        push_expected(i, lat);
        @(posedge clk); #1;
        bus.s = 1'b0;
        bus.load = mid_load;
        if (mid_load) bus.in = ~i;
        wlow = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = observed();
            if (!o.w) wlow++;
            check_eq({name, ".ctl"}, 32'(o), 32'(e));
            if (e.wr && e.vsel == 4'b0010)
                check_eq({name, ".sximm8"}, 32'(bus.sximm8), 32'({{8{i[7]}}, i[7:0]}));
            if (e.lc)
                check_eq({name, ".sximm5"}, 32'(bus.sximm5), 32'({{11{i[4]}}, i[4:0]}));
        end
        check_eq({name, ".wlow"}, 32'(wlow), 32'(lat));
        bus.load = 1'b0;
    endtask

    initial begin
        bus.in = '0; bus.load = 1'b0; bus.s = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst.ctl", 32'(observed()), 32'h200000);
        check_eq("rst.sximm8", 32'(bus.sximm8), 32'h0);
        reset_n = 1'b1;

        // Reset abandoned mid-ADD, during GET_B.
        @(negedge clk);
        bus.in = 16'hA148; bus.load = 1'b1; bus.s = 1'b1;
        @(posedge clk); #1;
        bus.s = 1'b0; bus.load = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("abort.getb_loadb", 32'(bus.loadb), 32'h1);
        reset_n = 1'b0;
        #1;
        check_eq("abort.w", 32'(bus.w), 32'h1);
        check_eq("abort.loadb", 32'(bus.loadb), 32'h0);
        check_eq("abort.write", 32'(bus.write), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("abort.idle_write", 32'(bus.write), 32'h0);
            check_eq("abort.idle_w", 32'(bus.w), 32'h1);
        end

        run_instr("movimm7",  16'hD007, 1'b0);
        run_instr("movimm-2", 16'hD1FE, 1'b0);
        run_instr("add",      16'hA148, 1'b0);
        run_instr("cmp",      16'hA900, 1'b0);
        run_instr("illegal",  16'hE000, 1'b0);
        run_instr("mvn",      16'hB860, 1'b1);
        run_instr("movreg",   16'hC080, 1'b1);
        run_instr("and",      16'hB5B3, 1'b1);
        run_instr("movregsh", 16'hC0F9, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
